pulse_stretch: RTL and testbench



---
 rtl/pulse_stretch.sv | 120 ++++++++++++
 tb/tb_pulse_stretch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch.sv
// N-channel LED pulse stretcher: minimum ON/OFF times with a saturating replay queue per channel.
// Define PULSE_STRETCH_OVF_EN to add the sticky o_overflow flags for dropped events.
module pulse_stretch #(
    parameter int unsigned ON_TIME  = 5000000,
    parameter int unsigned OFF_TIME = 5000000,
    parameter int unsigned N        = 1,
    parameter int unsigned PEND_W   = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_pulse,
    output logic [N-1:0] o_led,
    output logic [N-1:0] o_busy
`ifdef PULSE_STRETCH_OVF_EN
    ,
    output logic [N-1:0] o_overflow
`endif
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TIME - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TIME - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t            state;
        logic [CNT_W-1:0]  cnt;
        logic [PEND_W-1:0] pend;
        logic              prev;
        logic              ev;
        logic              pend_full;
`ifdef PULSE_STRETCH_OVF_EN
        logic              ovf;
        assign o_overflow[i] = ovf;
`endif

        assign ev        = i_pulse[i] & ~prev;
        assign pend_full = (pend == PEND_MAX);
        assign o_led[i]  = (state == ST_ON);
        assign o_busy[i] = (state != ST_IDLE);

        // Per-channel FSM; events seen while busy are queued unless the queue is full
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                state <= ST_IDLE;
                cnt   <= '0;
                pend  <= '0;
                prev  <= 1'b0;
`ifdef PULSE_STRETCH_OVF_EN
                ovf   <= 1'b0;
`endif
            end else begin
                prev <= i_pulse[i];
                case (state)
                    ST_IDLE: begin
                        if (ev) begin
                            state <= ST_ON;
                            cnt   <= '0;
                        end
                    end
                    ST_ON: begin
                        if (cnt == ON_LAST) begin
                            state <= ST_OFF;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (ev) begin
                            if (!pend_full) begin
                                pend <= pend + PEND_W'(1);
                            end
`ifdef PULSE_STRETCH_OVF_EN
                            else begin
                                ovf <= 1'b1;
                            end
`endif
                        end
                    end
                    ST_OFF: begin
                        if (cnt == OFF_LAST) begin
                            // A fresh event and a queued one cancel: start now, queue unchanged
                            cnt <= '0;
                            if (ev || (pend != '0)) begin
                                state <= ST_ON;
                                if (!ev) begin
                                    pend <= pend - PEND_W'(1);
                                end
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            if (ev) begin
                                if (!pend_full) begin
                                    pend <= pend + PEND_W'(1);
                                end
`ifdef PULSE_STRETCH_OVF_EN
                                else begin
                                    ovf <= 1'b1;
                                end
`endif
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: directed scenarios plus random events against a timeline-based reference model.
module tb_pulse_stretch;

    localparam int unsigned N        = 2;
    localparam int unsigned ON_TIME  = 8;
    localparam int unsigned OFF_TIME = 3;
    localparam int unsigned PEND_W   = 2;
    localparam int          PEND_MAX = (1 << PEND_W) - 1;

    logic         i_clk;
    logic         i_reset;
    logic [N-1:0] i_pulse;
    logic [N-1:0] o_led;
    logic [N-1:0] o_busy;
`ifdef PULSE_STRETCH_OVF_EN
    logic [N-1:0] o_overflow;
`endif

    pulse_stretch #(
        .ON_TIME (ON_TIME),
        .OFF_TIME(OFF_TIME),
        .N       (N),
        .PEND_W  (PEND_W)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_pulse   (i_pulse),
        .o_led     (o_led),
        .o_busy    (o_busy)
`ifdef PULSE_STRETCH_OVF_EN
        ,
        .o_overflow(o_overflow)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each channel is a timeline anchored at the edge its current pulse began
    int cyc;
    bit m_act [N];
    int m_start [N];
    int m_pend [N];
    bit m_prev [N];
    bit m_ovf [N];

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_act[c] = 0; m_start[c] = 0; m_pend[c] = 0; m_prev[c] = 0; m_ovf[c] = 0;
        end
    endfunction

    function automatic void model_edge(input logic [N-1:0] p);
        cyc++;
        for (int c = 0; c < N; c++) begin
            bit ev;
            int pos;
            ev = p[c] && !m_prev[c];
            m_prev[c] = p[c];
            if (!m_act[c]) begin
                if (ev) begin m_act[c] = 1; m_start[c] = cyc; end
            end else begin
                pos = cyc - m_start[c];
                if (pos == int'(ON_TIME + OFF_TIME)) begin
                    if (ev || m_pend[c] > 0) begin
                        m_start[c] = cyc;
                        if (!ev) m_pend[c]--;
                    end else begin
                        m_act[c] = 0;
                    end
                end else if (ev) begin
                    if (m_pend[c] < PEND_MAX) m_pend[c]++;
                    else m_ovf[c] = 1;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_led();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = m_act[c] && ((cyc - m_start[c]) < int'(ON_TIME));
        return r;
    endfunction

    function automatic logic [N-1:0] exp_busy();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = m_act[c];
        return r;
    endfunction

    function automatic logic [N-1:0] exp_ovf();
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = m_ovf[c];
        return r;
    endfunction

    logic [N-1:0] last_led;

    // Drive one cycle of input, advance the model at the edge, compare shortly after
    task automatic step(input logic [N-1:0] p);
        last_led = o_led;
        i_pulse = p;
        @(posedge i_clk);
        model_edge(p);
        #1;
        check("led", 32'(o_led), 32'(exp_led()));
        check("busy", 32'(o_busy), 32'(exp_busy()));
`ifdef PULSE_STRETCH_OVF_EN
        check("overflow", 32'(o_overflow), 32'(exp_ovf()));
`endif
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        i_pulse = '0;
        #1;
        model_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    int busy_cnt, led_cnt, rise_cnt, busy_low;

    initial begin
        cyc = 0;
        model_reset();
        i_reset = 1'b1;
        i_pulse = '0;
        // Held in reset while inputs toggle
        for (int k = 0; k < 4; k++) begin
            i_pulse = N'(k + 1);
            @(posedge i_clk);
            #1;
            check("reset_led", 32'(o_led), 32'(0));
            check("reset_busy", 32'(o_busy), 32'(0));
        end
        i_pulse = '0;
        i_reset = 1'b0;

        // Single pulse on ch0
        busy_cnt = 0; led_cnt = 0;
        step(2'b01);
        busy_cnt += int'(o_busy[0]); led_cnt += int'(o_led[0]);
        for (int k = 0; k < 15; k++) begin
            step(2'b00);
            busy_cnt += int'(o_busy[0]); led_cnt += int'(o_led[0]);
        end
        check("single_busy_cycles", 32'(busy_cnt), 32'(ON_TIME + OFF_TIME));
        check("single_led_cycles", 32'(led_cnt), 32'(ON_TIME));

        // Held level on ch1 gives one pulse
        rise_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(2'b10);
            if (o_led[1] && !last_led[1]) rise_cnt++;
        end
        for (int k = 0; k < 12; k++) step(2'b00);
        check("held_rises", 32'(rise_cnt), 32'(1));

        // Three events in the first ON window replay back to back
        busy_cnt = 0; rise_cnt = 0;
        for (int k = 0; k < 45; k++) begin
            step((k == 0 || k == 2 || k == 4) ? 2'b01 : 2'b00);
            busy_cnt += int'(o_busy[0]);
            if (o_led[0] && !last_led[0]) rise_cnt++;
        end
        check("queue_busy_cycles", 32'(busy_cnt), 32'(3 * (ON_TIME + OFF_TIME)));
        check("queue_rises", 32'(rise_cnt), 32'(3));

        // Saturation: six events on alternating cycles, two dropped
        rise_cnt = 0;
        for (int k = 0; k < 70; k++) begin
            step((k < 12 && (k % 2) == 0) ? 2'b01 : 2'b00);
            if (o_led[0] && !last_led[0]) rise_cnt++;
        end
        check("sat_rises", 32'(rise_cnt), 32'(4));
`ifdef PULSE_STRETCH_OVF_EN
        check("sat_ovf_sticky", 32'(o_overflow[0]), 32'(1));
`endif
        do_reset();

        // Event exactly in the final OFF cycle restarts with no idle gap
        busy_low = 0; rise_cnt = 0;
        for (int k = 0; k < 2 * int'(ON_TIME + OFF_TIME); k++) begin
            step((k == 0 || k == int'(ON_TIME + OFF_TIME)) ? 2'b01 : 2'b00);
            busy_low += int'(!o_busy[0]);
            if (o_led[0] && !last_led[0]) rise_cnt++;
        end
        check("boundary_busy_gap", 32'(busy_low), 32'(0));
        check("boundary_rises", 32'(rise_cnt), 32'(2));
        for (int k = 0; k < 12; k++) step(2'b00);

        // Final-OFF event with two queued: queue stays at two, four pulses total
        rise_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            step((k == 0 || k == 2 || k == 4 || k == int'(ON_TIME + OFF_TIME)) ? 2'b01 : 2'b00);
            if (o_led[0] && !last_led[0]) rise_cnt++;
        end
        check("boundary_pend_rises", 32'(rise_cnt), 32'(4));

        // Async reset mid-ON drops outputs before any clock edge
        step(2'b11);
        step(2'b00);
        step(2'b00);
        #2;
        i_reset = 1'b1;
        #1;
        check("async_led", 32'(o_led), 32'(0));
        check("async_busy", 32'(o_busy), 32'(0));
        model_reset();
        @(posedge i_clk);
        #1;
        i_pulse = 2'b01;
        i_reset = 1'b0;
        // Input already high at release counts as one event
        step(2'b01);
        step(2'b01);

        // Random events
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] p;
            for (int c = 0; c < N; c++) p[c] = ($urandom_range(0, 3) == 0);
            step(p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
